// File: rtl/hex_display_scheduler.sv
// hex_display_scheduler
//   Lets two requesters share one external combinational seven-segment
//   decoder and a bank of NUM_DIGITS HEX displays. Requester B (error or
//   syndrome status) has priority over requester A (normal data).
//   The owner's nibbles are copied into a shadow register. They are then
//   scanned one digit per cycle through the decoder, and the registered
//   segment patterns are held for HOLD_CYCLES before the next arbitration.
//
//   Optional build macro: HEX_SCHED_PREEMPT_EN
//     When defined, a B request aborts A's HOLD on the next edge.
//     When undefined, B waits for A's terminal count.
//
// Ports
//   clk, reset     : system clock; synchronous active-high reset
//   req_a, data_a  : requester A level request and nibbles (digit i = [4i+3:4i])
//   req_b, data_b  : requester B (priority), same packing
//   dec_in         : nibble presented to the shared decoder
//   dec_seg        : decoder result for dec_in, same cycle, active-low
//   hex_out        : registered segments, digit i = [7i+6:7i]
//   gnt_a, gnt_b   : registered, mutually exclusive ownership flags
//   frame_done     : one-cycle pulse in the first HOLD cycle
//   busy           : high in LOAD or SCAN

// One HEX digit's segment register. It is blanked on reset or by the blank
// strobe, and otherwise captures the decoder output when selected.
module hex_digit_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       blank,
  input  logic       we,
  input  logic [6:0] seg,
  output logic [6:0] q
);
  always_ff @(posedge clk) begin
    if (reset || blank) q <= 7'h7F;
    else if (we)        q <= seg;
  end
endmodule

module hex_display_scheduler #(
  parameter int NUM_DIGITS  = 6,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_a,
  input  logic [4*NUM_DIGITS-1:0] data_a,
  input  logic                    req_b,
  input  logic [4*NUM_DIGITS-1:0] data_b,
  output logic [3:0]              dec_in,
  input  logic [6:0]              dec_seg,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    gnt_a,
  output logic                    gnt_b,
  output logic                    frame_done,
  output logic                    busy
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_HOLD} state_t;

  state_t                       state, state_nxt;
  logic                         gnt_a_nxt, gnt_b_nxt;
  logic [NUM_DIGITS-1:0][3:0]   shadow;
  logic [IW-1:0]                idx;
  logic [CW-1:0]                cnt;
  logic                         hold_done;
  logic                         scan_last;
  logic                         blank_all;
  logic [NUM_DIGITS-1:0]        dig_we;

  assign hold_done = (cnt == LAST_CNT);
  assign scan_last = (state == S_SCAN) && (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt_a <= gnt_a_nxt;
      gnt_b <= gnt_b_nxt;
    end
  end

  // Next state and ownership
  always_comb begin
    state_nxt = state;
    gnt_a_nxt = gnt_a;
    gnt_b_nxt = gnt_b;
    case (state)
      S_IDLE: begin
        gnt_a_nxt = 1'b0;
        gnt_b_nxt = 1'b0;
        if (req_b) begin
          state_nxt = S_LOAD;
          gnt_b_nxt = 1'b1;
        end else if (req_a) begin
          state_nxt = S_LOAD;
          gnt_a_nxt = 1'b1;
        end
      end
      S_LOAD: state_nxt = S_SCAN;
      S_SCAN: if (idx == LAST_IDX) state_nxt = S_HOLD;
      S_HOLD: begin
        // Re-arbitrate only at terminal count. The current owner may win
        // again, and that refreshes its snapshot.
        if (hold_done) begin
          if (req_b) begin
            state_nxt = S_LOAD;
            gnt_a_nxt = 1'b0;
            gnt_b_nxt = 1'b1;
          end else if (req_a) begin
            state_nxt = S_LOAD;
            gnt_a_nxt = 1'b1;
            gnt_b_nxt = 1'b0;
          end else begin
            state_nxt = S_IDLE;
            gnt_a_nxt = 1'b0;
            gnt_b_nxt = 1'b0;
          end
        end
`ifdef HEX_SCHED_PREEMPT_EN
        // Error status cuts A's hold short. LOAD and SCAN always complete.
        if (gnt_a && req_b) begin
          state_nxt = S_LOAD;
          gnt_a_nxt = 1'b0;
          gnt_b_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Snapshot, scan index, hold counter, frame pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow     <= '0;
      idx        <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= scan_last;
      case (state)
        S_IDLE: begin
          idx <= '0;
          cnt <= '0;
        end
        S_LOAD: begin
          // Grant was decided on the previous edge, so it selects the bus here.
          shadow <= gnt_b ? data_b : data_a;
          idx    <= '0;
        end
        S_SCAN: begin
          // The index stays on the last digit so that HOLD keeps presenting it.
          if (idx != LAST_IDX) idx <= idx + 1'b1;
          cnt <= '0;
        end
        S_HOLD: if (!hold_done) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    dec_in = 4'h0;
    if (state == S_SCAN || state == S_HOLD) dec_in = shadow[idx];
  end

  assign busy = (state == S_LOAD) || (state == S_SCAN);

  // Blank while idle, and on the edge that returns to IDLE, so that the
  // display goes dark as soon as nobody owns it.
  assign blank_all = (state == S_IDLE) || ((state == S_HOLD) && (state_nxt == S_IDLE));

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign dig_we[g] = (state == S_SCAN) && (idx == IW'(g));
    hex_digit_reg u_dig (
      .clk   (clk),
      .reset (reset),
      .blank (blank_all),
      .we    (dig_we[g]),
      .seg   (dec_seg),
      .q     (hex_out[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Bench for hex_display_scheduler (NUM_DIGITS=6, HOLD_CYCLES=8).
// The bench supplies a model of the shared decoder. A timeline model counts
// cycles since each grant and predicts every output on every cycle. Directed
// scenarios are followed by a random phase.
module tb_hex_display_scheduler;
  localparam int N = 6;
  localparam int H = 8;

  logic           clk = 1'b0;
  logic           reset, req_a, req_b;
  logic [4*N-1:0] data_a, data_b;
  logic [3:0]     dec_in;
  logic [6:0]     dec_seg;
  logic [7*N-1:0] hex_out;
  logic           gnt_a, gnt_b, frame_done, busy;

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
    endcase
  endfunction

  assign dec_seg = seg7(dec_in);

  hex_display_scheduler #(.NUM_DIGITS(N), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .req_a(req_a), .data_a(data_a), .req_b(req_b),
    .data_b(data_b), .dec_in(dec_in), .dec_seg(dec_seg), .hex_out(hex_out),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .frame_done(frame_done), .busy(busy)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model. m_ph is the number of cycles since the grant (-1 = idle).
  // Phase 0 = load, 1..N = scanning digit ph-1, N+1..N+H = hold count ph-N-1.
  int         m_own;           // 0 none, 1 A, 2 B
  int         m_ph;
  logic [3:0] m_snap [N];
  logic [6:0] m_disp [N];

  task automatic arbitrate();
    if (req_b)      begin m_own = 2; m_ph = 0; end
    else if (req_a) begin m_own = 1; m_ph = 0; end
    else begin
      m_own = 0; m_ph = -1;
      for (int i = 0; i < N; i++) m_disp[i] = 7'h7F;
    end
  endtask

  task automatic model_step();
    logic [4*N-1:0] bus;
    logic           pre;
    if (reset) begin
      m_own = 0; m_ph = -1;
      for (int i = 0; i < N; i++) begin m_disp[i] = 7'h7F; m_snap[i] = 4'h0; end
    end else if (m_ph < 0) begin
      if (req_b || req_a) arbitrate();
    end else if (m_ph == 0) begin
      bus = (m_own == 2) ? data_b : data_a;
      for (int i = 0; i < N; i++) m_snap[i] = bus[4*i +: 4];
      m_ph++;
    end else if (m_ph <= N) begin
      m_disp[m_ph-1] = seg7(m_snap[m_ph-1]);
      m_ph++;
    end else begin
      pre = 1'b0;
`ifdef HEX_SCHED_PREEMPT_EN
      pre = (m_own == 1) && req_b;
`endif
      if (pre || (m_ph - N - 1 == H - 1)) arbitrate();
      else m_ph++;
    end
  endtask

  task automatic compare_all();
    logic [7*N-1:0] eh;
    logic [3:0]     ed;
    for (int i = 0; i < N; i++) eh[7*i +: 7] = m_disp[i];
    ed = 4'h0;
    if (m_ph >= 1 && m_ph <= N) ed = m_snap[m_ph-1];
    else if (m_ph > N)          ed = m_snap[N-1];
    chk("hex_out", hex_out, eh);
    chk("gnt_a", gnt_a, m_own == 1);
    chk("gnt_b", gnt_b, m_own == 2);
    chk("busy", busy, m_ph >= 0 && m_ph <= N);
    chk("frame_done", frame_done, m_ph == N + 1);
    chk("dec_in", dec_in, ed);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1 compare_all();
  endtask

  task automatic wait_fd(input string tag, output int n);
    n = 0;
    do begin cyc(); n++; end while (!frame_done && n < 40);
    chk(tag, frame_done, 1'b1);
  endtask

  task automatic wait_gnt_b(input string tag, output int n);
    n = 0;
    do begin cyc(); n++; end while (!gnt_b && n < 40);
    chk(tag, gnt_b, 1'b1);
  endtask

  int n;

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // A alone: latency and frame contents
    req_a = 1'b1; data_a = 24'h000001;
    wait_fd("a_frame_done", n);
    chk("a_latency", n, 8);
    chk("a_frame", hex_out, {{5{7'h40}}, 7'h79});
    req_a = 1'b0;
    repeat (H + 2) cyc();
    chk("a_idle_blank", hex_out, {N{7'h7F}});

    // Simultaneous requests: B wins
    req_a = 1'b1; req_b = 1'b1; data_b = 24'hFFFFFF;
    cyc();
    chk("both_gnt_b", gnt_b, 1'b1);
    chk("both_gnt_a", gnt_a, 1'b0);
    wait_fd("both_frame_done", n);
    chk("b_frame", hex_out, {N{7'h0E}});
    req_a = 1'b0; req_b = 1'b0;
    repeat (H + 2) cyc();

    // Data change during HOLD is ignored until the refresh
    req_a = 1'b1; data_a = 24'h000001;
    wait_fd("hold_fd1", n);
    data_a = 24'h888888;
    cyc(); cyc();
    chk("hold_unchanged", hex_out, {{5{7'h40}}, 7'h79});
    wait_fd("hold_fd2", n);
    chk("hold_refresh", hex_out, {N{7'h00}});

    // req_b rises at hold count 2 while A owns
    cyc(); cyc();
    req_b = 1'b1; data_b = 24'h123456;
    wait_gnt_b("b_over_a", n);
`ifdef HEX_SCHED_PREEMPT_EN
    chk("b_over_a_lat", n, 1);
`else
    chk("b_over_a_lat", n, 6);
`endif
    req_a = 1'b0; req_b = 1'b0;
    repeat (30) cyc();

    // Reset mid-scan
    req_a = 1'b1; data_a = 24'h345678;
    repeat (4) cyc();
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    cyc();
    chk("rst_hex", hex_out, {N{7'h7F}});
    chk("rst_gnt", {gnt_a, gnt_b}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0; req_a = 1'b0;
    cyc();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req_a = ~req_a;
      if ($urandom_range(9) == 0) req_b = ~req_b;
      if ($urandom_range(3) == 0) data_a = 24'($urandom);
      if ($urandom_range(3) == 0) data_b = 24'($urandom);
      reset = ($urandom_range(299) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
